// File: rtl/gray_conv_pkg.sv
// gray_conv_pkg
//   Shared definitions for the pipelined binary/Gray converter.
//   - MODE_BIN2GRAY / MODE_GRAY2BIN : values carried on the mode bit.
//   - seg_bounds_t / seg_bounds()   : segment width and the bit range that
//     pipeline stage k resolves in the Gray-to-binary direction. Segments are
//     counted from the MSB; the last one may be narrower, and stages past the
//     last non-empty segment get hi < lo (an empty range).
package gray_conv_pkg;

  localparam logic MODE_BIN2GRAY = 1'b0;
  localparam logic MODE_GRAY2BIN = 1'b1;

  typedef struct packed {
    int seg;  // ceil(data_width / stages)
    int hi;   // top bit of the segment (negative for a surplus stage)
    int lo;   // bottom bit of the segment, clamped at 0
  } seg_bounds_t;

  function automatic seg_bounds_t seg_bounds(input int data_width,
                                             input int stages,
                                             input int k);
    seg_bounds_t b;
    b.seg = (data_width + stages - 1) / stages;
    b.hi  = data_width - 1 - k * b.seg;
    b.lo  = data_width - (k + 1) * b.seg;
    if (b.lo < 0) begin
      b.lo = 0;
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_code_converter_pipe_stage.sv
// gray_conv_stage
//   One register stage of the converter pipeline: valid, mode, word and
//   carry registers plus the conversion work assigned to this stage.
//   - Binary-to-Gray is done entirely in stage 0; later stages pass through.
//   - Gray-to-binary: this stage resolves its own segment (MSB-first) using
//     in_carry as the seed for the segment's top bit and produces the
//     segment's LSB binary bit as carry for the next stage. Bits below the
//     segment stay raw Gray; bits above it were resolved upstream.
// Ports
//   clk, srst      clock, synchronous active-high reset (clears everything)
//   load           capture the upstream word this cycle
//   in_valid/in_mode/in_data/in_carry   upstream stage (or pipeline input)
//   valid_reg/mode_reg/data_reg/carry_reg  registered stage contents
module gray_conv_stage
  import gray_conv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 4,
  parameter int STAGE_IDX  = 0
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  load,
  input  logic                  in_valid,
  input  logic                  in_mode,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_carry,
  output logic                  valid_reg,
  output logic                  mode_reg,
  output logic [DATA_WIDTH-1:0] data_reg,
  output logic                  carry_reg
);

  localparam seg_bounds_t BOUNDS = seg_bounds(DATA_WIDTH, STAGES, STAGE_IDX);
  localparam int SEG_HI = BOUNDS.hi;
  localparam int SEG_LO = BOUNDS.lo;

  logic [DATA_WIDTH-1:0] data_next;
  logic                  carry_next;
  logic                  prefix;

  // For a surplus stage SEG_HI < SEG_LO, the loop body never runs, and the
  // word plus carry pass straight through.
  always_comb begin
    data_next  = in_data;
    carry_next = in_carry;
    prefix     = in_carry;
    if (in_mode == MODE_GRAY2BIN) begin
      for (int i = SEG_HI; i >= SEG_LO; i--) begin
        prefix       = in_data[i] ^ prefix;
        data_next[i] = prefix;
      end
      carry_next = prefix;
    end else if (STAGE_IDX == 0) begin
      data_next = in_data ^ (in_data >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      valid_reg <= 1'b0;
      mode_reg  <= 1'b0;
      data_reg  <= '0;
      carry_reg <= 1'b0;
    end else if (load) begin
      // Loading with in_valid low inserts a bubble; the stale word behind it
      // is never observed because valid_reg gates every consumer.
      valid_reg <= in_valid;
      mode_reg  <= in_mode;
      data_reg  <= data_next;
      carry_reg <= carry_next;
    end
  end

endmodule

// File: rtl/gray_code_converter_pipe.sv
// gray_code_converter_pipe
//   Parametrised pipelined binary<->Gray converter with a per-word mode bit
//   and valid/ready flow control. The Gray-to-binary prefix-XOR chain is cut
//   into STAGES segments, one per register stage, so wide words close timing.
//   This level only holds the load/ready chain and the port mapping.
// Parameters
//   DATA_WIDTH  word width (>= 2)
//   STAGES      pipeline depth (1..DATA_WIDTH)
// Ports
//   Clock_In, Reset_In               clock, synchronous active-high reset
//   Enable_In                        global stall: nothing moves when low
//   Mode_In, Data_In, Data_Valid_In  input word (0 = bin->Gray, 1 = Gray->bin)
//   Data_Ready_Out                   input can be accepted this cycle
//   Data_Out, Mode_Out, Data_Valid_Out  converted word from the last stage
//   Data_Ready_In                    downstream accepts the output word
//   Busy_Out                         any stage holds a valid word
module gray_code_converter_pipe
  import gray_conv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 4
) (
  input  logic                  Clock_In,
  input  logic                  Reset_In,
  input  logic                  Enable_In,
  input  logic                  Mode_In,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Data_Valid_In,
  output logic                  Data_Ready_Out,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  Mode_Out,
  output logic                  Data_Valid_Out,
  input  logic                  Data_Ready_In,
  output logic                  Busy_Out
);

  logic [STAGES-1:0]     stage_valid;
  logic [STAGES-1:0]     stage_mode;
  logic [DATA_WIDTH-1:0] stage_data  [STAGES];
  logic                  stage_carry [STAGES];
  logic [STAGES-1:0]     stage_load;

  logic [STAGES-1:0]     feed_valid;
  logic [STAGES-1:0]     feed_mode;
  logic [DATA_WIDTH-1:0] feed_data  [STAGES];
  logic                  feed_carry [STAGES];

  // stage_load[k]: stage k captures its upstream word this cycle. A stage can
  // load when it is empty or when its own word moves on in the same cycle, so
  // bubbles collapse. The chain ripples back from Data_Ready_In without a
  // register, which makes Data_Ready_Out combinational from Data_Ready_In.
  always_comb begin
    logic ripple;
    stage_load = '0;
    ripple     = Enable_In && (!stage_valid[STAGES-1] || Data_Ready_In);
    stage_load[STAGES-1] = ripple;
    for (int k = STAGES - 2; k >= 0; k--) begin
      ripple        = Enable_In && (!stage_valid[k] || ripple);
      stage_load[k] = ripple;
    end
  end

  assign Data_Ready_Out = stage_load[0];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_feed_input
      // The first segment has no upstream binary bit; its seed is 0.
      assign feed_valid[gi] = Data_Valid_In;
      assign feed_mode[gi]  = Mode_In;
      assign feed_data[gi]  = Data_In;
      assign feed_carry[gi] = 1'b0;
    end else begin : g_feed_stage
      assign feed_valid[gi] = stage_valid[gi-1];
      assign feed_mode[gi]  = stage_mode[gi-1];
      assign feed_data[gi]  = stage_data[gi-1];
      assign feed_carry[gi] = stage_carry[gi-1];
    end

    gray_conv_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .STAGES     (STAGES),
      .STAGE_IDX  (gi)
    ) u_stage (
      .clk       (Clock_In),
      .srst      (Reset_In),
      .load      (stage_load[gi]),
      .in_valid  (feed_valid[gi]),
      .in_mode   (feed_mode[gi]),
      .in_data   (feed_data[gi]),
      .in_carry  (feed_carry[gi]),
      .valid_reg (stage_valid[gi]),
      .mode_reg  (stage_mode[gi]),
      .data_reg  (stage_data[gi]),
      .carry_reg (stage_carry[gi])
    );
  end

  assign Data_Out       = stage_data[STAGES-1];
  assign Mode_Out       = stage_mode[STAGES-1];
  assign Data_Valid_Out = stage_valid[STAGES-1];
  assign Busy_Out       = |stage_valid;

endmodule
